// File: rtl/bcd_addsub_serial.sv
// Digit-serial binary/BCD adder-subtractor: one 4-bit digit per clock, LSB digit first.
// Carry follows 6502 rules, so on subtract carry_out=1 means no borrow.
module bcd_addsub_serial #(
    parameter int unsigned DIGITS = 2,
    parameter bit          DEC_EN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_sub,
    input  logic                  i_dec_mode,
    input  logic                  i_carry_in,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4*DIGITS-1:0]   o_y,
    output logic                  o_carry_out,
    output logic                  o_zero,
    output logic                  o_neg,
    output logic                  o_ovf
);
    localparam int unsigned   W      = 4 * DIGITS;
    localparam int unsigned   KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_bi;
    logic [W-1:0]  r_acc;
    logic          r_dec;
    logic          r_c;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_y;
    logic          r_carry_out;
    logic          r_zero;
    logic          r_neg;
    logic          r_ovf;

    logic          w_dec;
    logic [W-1:0]  w_bi;
    logic [KW+1:0] w_idx;
    logic [3:0]    w_a_dig;
    logic [3:0]    w_b_dig;
    logic [4:0]    w_sum;
    logic [3:0]    w_dig;
    logic          w_c_next;
    logic [W-1:0]  w_acc_next;

    assign w_dec = i_dec_mode & DEC_EN;

    // Subtraction becomes addition of the radix-minus-one complement of B.
    always_comb begin
        w_bi = i_b;
        if (i_sub) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                w_bi[i*4 +: 4] = w_dec ? (4'd9 - i_b[i*4 +: 4]) : ~i_b[i*4 +: 4];
            end
        end
    end

    assign w_idx   = {r_k, 2'b00};
    assign w_a_dig = r_a[w_idx +: 4];
    assign w_b_dig = r_bi[w_idx +: 4];
    assign w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_c};

    always_comb begin
        w_dig    = w_sum[3:0];
        w_c_next = w_sum[4];
        if (r_dec) begin
            w_c_next = 1'b0;
            if (w_sum > 5'd9) begin
                w_dig    = w_sum[3:0] + 4'd6;
                w_c_next = 1'b1;
            end
        end
        w_acc_next             = r_acc;
        w_acc_next[w_idx +: 4] = w_dig;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_k         <= '0;
            r_a         <= '0;
            r_bi        <= '0;
            r_acc       <= '0;
            r_dec       <= 1'b0;
            r_c         <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a        <= i_a;
                        r_bi       <= w_bi;
                        r_dec      <= w_dec;
                        r_c        <= i_carry_in;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StCalc;
                    end
                end
                StCalc: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_c_next;
                    r_k   <= r_k + KW'(1);
                    if (r_k == LAST_K) begin
                        // Results are published only here so y/flags hold through IDLE.
                        r_y         <= w_acc_next;
                        r_carry_out <= w_c_next;
                        r_zero      <= (w_acc_next == '0);
                        r_neg       <= w_acc_next[W-1];
                        r_ovf       <= !r_dec && (r_a[W-1] == r_bi[W-1])
                                       && (w_acc_next[W-1] != r_a[W-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;
    assign o_carry_out = r_carry_out;
    assign o_zero      = r_zero;
    assign o_neg       = r_neg;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial: three instances (2-digit, 4-digit, 2-digit binary-only)
// checked against an arithmetic model plus literal expectations.
module tb_bcd_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        dec = 1'b0;
    logic        carry_in = 1'b0;
    logic [2:0]  in_valid = '0;
    logic [2:0]  out_ready = '0;
    wire  [2:0]  in_ready, out_valid, carry, zero, neg, ovf;
    wire  [7:0]  y0, y2;
    wire  [15:0] y1;

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    bit   [2:0]  armed = '0;
    logic [15:0] e_y [3];
    bit          e_c [3];
    bit          e_z [3];
    bit          e_n [3];
    bit          e_v [3];

    always #5 clk = ~clk;

    bcd_addsub_serial #(.DIGITS(2), .DEC_EN(1'b1)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_a(a[7:0]), .i_b(b[7:0]), .i_sub(sub), .i_dec_mode(dec), .i_carry_in(carry_in),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_y(y0),
        .o_carry_out(carry[0]), .o_zero(zero[0]), .o_neg(neg[0]), .o_ovf(ovf[0])
    );

    bcd_addsub_serial #(.DIGITS(4), .DEC_EN(1'b1)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_a(a), .i_b(b), .i_sub(sub), .i_dec_mode(dec), .i_carry_in(carry_in),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_y(y1),
        .o_carry_out(carry[1]), .o_zero(zero[1]), .o_neg(neg[1]), .o_ovf(ovf[1])
    );

    bcd_addsub_serial #(.DIGITS(2), .DEC_EN(1'b0)) u_bin (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_a(a[7:0]), .i_b(b[7:0]), .i_sub(sub), .i_dec_mode(dec), .i_carry_in(carry_in),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]), .o_y(y2),
        .o_carry_out(carry[2]), .o_zero(zero[2]), .o_neg(neg[2]), .o_ovf(ovf[2])
    );

    function automatic logic [15:0] gy(input int i);
        if (i == 0) return {8'h00, y0};
        if (i == 1) return y1;
        return {8'h00, y2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint bcd2int(input logic [15:0] v, input int nd);
        longint r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input longint v, input int nd);
        logic [15:0] r = '0;
        longint      t = v;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Whole-number arithmetic view of the operation.
    task automatic model(input int nd, input bit dm, input bit sb, input logic [15:0] av,
                         input logic [15:0] bv, input bit cin, output logic [15:0] ey,
                         output bit ec, output bit ez, output bit en, output bit ev);
        longint w = 4 * nd;
        longint m = longint'(1) << w;
        longint ua = longint'(av);
        longint ub = longint'(bv);
        longint r, sa, sbv, rs, pw;
        if (dm) begin
            pw = 1;
            for (int i = 0; i < nd; i++) pw = pw * 10;
            if (sb) begin
                r  = bcd2int(av, nd) - bcd2int(bv, nd) - (1 - longint'(cin));
                ec = (r >= 0);
                if (r < 0) r = r + pw;
            end else begin
                r  = bcd2int(av, nd) + bcd2int(bv, nd) + longint'(cin);
                ec = (r >= pw);
            end
            ey = int2bcd(r % pw, nd);
            ev = 1'b0;
        end else begin
            r   = sb ? ua + (m - 1 - ub) + longint'(cin) : ua + ub + longint'(cin);
            ey  = 16'(r % m);
            ec  = (r >= m);
            sa  = (ua >= m / 2) ? ua - m : ua;
            sbv = (ub >= m / 2) ? ub - m : ub;
            rs  = sb ? sa - sbv - (1 - longint'(cin)) : sa + sbv + longint'(cin);
            ev  = (rs >= m / 2) || (rs < -(m / 2));
        end
        ez = (ey == 16'h0);
        en = ey[nd*4-1];
    endtask

    task automatic arm(input int i, input logic [15:0] av, input logic [15:0] bv,
                       input bit sb, input bit dm, input bit cin);
        logic [15:0] ey;
        bit          ec, ez, en, ev;
        model((i == 1) ? 4 : 2, dm && (i != 2), sb, av, bv, cin, ey, ec, ez, en, ev);
        e_y[i] = ey; e_c[i] = ec; e_z[i] = ez; e_n[i] = en; e_v[i] = ev;
        armed[i] = 1'b1;
    endtask

    // Every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i]) begin
                    chk($sformatf("mon%0d_expected_valid", i), 32'(armed[i]), 1);
                    if (armed[i]) begin
                        chk($sformatf("mon%0d_y", i), gy(i), e_y[i]);
                        chk($sformatf("mon%0d_carry", i), carry[i], e_c[i]);
                        chk($sformatf("mon%0d_zero", i), zero[i], e_z[i]);
                        chk($sformatf("mon%0d_neg", i), neg[i], e_n[i]);
                        chk($sformatf("mon%0d_ovf", i), ovf[i], e_v[i]);
                        chk($sformatf("mon%0d_in_ready_low", i), in_ready[i], 0);
                    end
                end
            end
        end
    end

    task automatic wait_valid(input int i, output int n);
        n = 0;
        while (!out_valid[i] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_result(input int i, input string name);
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        armed[i] = 1'b0;
        chk({name, "_valid_drop"}, out_valid[i], 0);
        chk({name, "_in_ready_back"}, in_ready[i], 1);
    endtask

    task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input bit sb, input bit dm, input bit cin,
                          input logic [15:0] lit_y, input bit lit_c, input string name);
        int n;
        arm(i, av, bv, sb, dm, cin);
        a = av; b = bv; sub = sb; dec = dm; carry_in = cin;
        in_valid[i] = 1'b1;
        n = 0;
        while (!in_ready[i] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_ready_before_accept"}, in_ready[i], 1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        wait_valid(i, n);
        chk({name, "_latency"}, n, (i == 1) ? 4 : 2);
        chk({name, "_y_literal"}, gy(i), lit_y);
        chk({name, "_c_literal"}, carry[i], lit_c);
        release_result(i, name);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d_in_ready", i), in_ready[i], 1);
            chk($sformatf("reset%0d_out_valid", i), out_valid[i], 0);
            chk($sformatf("reset%0d_y", i), gy(i), 0);
            chk($sformatf("reset%0d_flags", i), {carry[i], zero[i], neg[i], ovf[i]}, 0);
        end

        run_op(0, 16'h0045, 16'h0038, 0, 1, 0, 16'h0083, 0, "dec_add_45_38");
        run_op(0, 16'h0099, 16'h0001, 0, 1, 0, 16'h0000, 1, "dec_add_99_01");
        chk("dec_add_99_01_zero_literal", zero[0], 1);
        run_op(0, 16'h0052, 16'h0027, 1, 1, 1, 16'h0025, 1, "dec_sub_52_27");
        run_op(1, 16'h1000, 16'h0001, 1, 1, 1, 16'h0999, 1, "dec_sub_1000_0001");
        run_op(1, 16'h0000, 16'h0001, 1, 1, 1, 16'h9999, 0, "dec_sub_0000_0001");
        run_op(0, 16'h007F, 16'h0001, 0, 0, 0, 16'h0080, 0, "bin_add_7f_01");
        chk("bin_add_7f_01_ovf_literal", ovf[0], 1);
        chk("bin_add_7f_01_neg_literal", neg[0], 1);
        run_op(0, 16'h0050, 16'h00B0, 1, 0, 1, 16'h00A0, 0, "bin_sub_50_b0");
        chk("bin_sub_50_b0_ovf_literal", ovf[0], 1);
        run_op(0, 16'h00FF, 16'h0001, 0, 0, 1, 16'h0001, 1, "bin_add_ff_01_c");
        run_op(2, 16'h0009, 16'h0001, 0, 1, 0, 16'h000A, 0, "decen0_add_09_01");

        // Reset during CALC at k=1 on the 4-digit unit aborts the operation.
        arm(1, 16'h1111, 16'h2222, 0, 1, 0);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; dec = 1'b1; carry_in = 1'b0;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        armed[1] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", in_ready[1], 1);
        chk("abort_y_cleared", gy(1), 0);
        chk("abort_flags_cleared", {carry[1], zero[1], neg[1], ovf[1]}, 0);
        repeat (8) @(posedge clk);
        #1 chk("abort_no_valid", out_valid[1], 0);
        run_op(1, 16'h1234, 16'h4321, 0, 1, 0, 16'h5555, 0, "after_abort_add");
        run_op(1, 16'h1234, 16'h1234, 1, 0, 1, 16'h0000, 1, "bin_sub_equal");
        chk("bin_sub_equal_zero_literal", zero[1], 1);

        // Back-pressure with in_valid held; operands change after acceptance.
        arm(0, 16'h0012, 16'h0034, 0, 1, 0);
        a = 16'h0012; b = 16'h0034; sub = 1'b0; dec = 1'b1; carry_in = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold_first_accept", in_ready[0], 0);
        a = 16'h0025; b = 16'h0025;
        wait_valid(0, n);
        chk("hold_latency", n, 2);
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_in_ready_low", in_ready[0], 0);
            chk("hold_valid_high", out_valid[0], 1);
            chk("hold_y_literal", gy(0), 16'h0046);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("hold_in_ready_rise", in_ready[0], 1);
        chk("hold_valid_drop", out_valid[0], 0);
        arm(0, 16'h0025, 16'h0025, 0, 1, 0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("hold_second_accept", in_ready[0], 0);
        wait_valid(0, n);
        chk("hold_second_latency", n, 2);
        chk("hold_second_y_literal", gy(0), 16'h0050);
        release_result(0, "hold_second");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
